// File: rtl/averager_reader_if.sv
// AXI4-Stream channel carrying the averager readout.
//   tdata  : stream payload
//   tvalid : payload valid
//   tready : sink ready
//   tlast  : final word of a frame
// master drives tdata/tvalid/tlast; slave drives tready.
interface averager_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/averager_reader.sv
// Readout engine for the averager accumulation BRAM: sweeps words
// 0..count_max through the second BRAM port and streams them out with
// backpressure, latching n_avg alongside the frame.
//   clk, rst          : clock, async active-high reset
//   start, avg_ready  : frame request, averager ready
//   count_max         : last word index of the frame
//   n_avg_in / n_avg  : averaging count in / latched at start
//   bram_addr/en/rdata: BRAM read port (byte address, enable, data)
//   m_axis            : AXI4-Stream master
//   busy, done        : readout in progress, end-of-frame pulse
//   overrun           : sticky, avg_ready dropped during readout
module averager_reader #(
  parameter int unsigned FAST_COUNT_WIDTH = 13,
  parameter int unsigned SLOW_COUNT_WIDTH = 19,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned READ_LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        avg_ready,
  input  logic [FAST_COUNT_WIDTH-1:0] count_max,
  input  logic [SLOW_COUNT_WIDTH-1:0] n_avg_in,
  output logic [FAST_COUNT_WIDTH+1:0] bram_addr,
  output logic                        bram_en,
  input  logic [DATA_WIDTH-1:0]       bram_rdata,
  averager_reader_if.master           m_axis,
  output logic [SLOW_COUNT_WIDTH-1:0] n_avg,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  // Index is one bit wider than the word index so a full-scale frame
  // terminates the <= compare without wrapping.
  localparam int unsigned IDX_W = FAST_COUNT_WIDTH + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                      state, state_next;
  logic [FAST_COUNT_WIDTH-1:0] cmax_reg;
  logic [IDX_W-1:0]            issue_idx;
  logic [IDX_W-1:0]            ret_idx;
  logic [READ_LATENCY-1:0]     vld_sr;
  logic [CNT_W-1:0]            in_flight;
  logic [CNT_W-1:0]            fifo_count;
  logic [DATA_WIDTH-1:0]       fifo_data [FIFO_DEPTH];
  logic                        fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;

  logic             accept, issue, done_set;
  logic             push, pop, ret_last;
  logic [SUM_W-1:0] occupancy;
  logic [IDX_W-1:0] cmax_ext;

  assign cmax_ext  = {1'b0, cmax_reg};
  assign occupancy = SUM_W'(in_flight) + SUM_W'(fifo_count);
  assign push      = vld_sr[READ_LATENCY-1];
  assign pop       = m_axis.tvalid && m_axis.tready;
  assign ret_last  = (ret_idx == cmax_ext);

  // Stream side is driven straight from the FIFO head.
  assign m_axis.tvalid = (fifo_count != '0);
  assign m_axis.tdata  = fifo_data[rd_ptr];
  assign m_axis.tlast  = fifo_last[rd_ptr];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle controls; issue credit counts reads in
  // flight plus buffered words so the FIFO can never overflow.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start && avg_ready) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if ((issue_idx <= cmax_ext) && (occupancy < SUM_W'(FIFO_DEPTH))) begin
          issue = 1'b1;
          if (issue_idx == cmax_ext) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_axis.tlast) begin
          done_set   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame control, read issue and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmax_reg  <= '0;
      n_avg     <= '0;
      issue_idx <= '0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bram_en <= issue;
      done    <= done_set;
      if (issue) begin
        bram_addr <= {issue_idx[FAST_COUNT_WIDTH-1:0], 2'b00};
        issue_idx <= issue_idx + IDX_W'(1);
      end
      if (accept) begin
        cmax_reg  <= count_max;
        n_avg     <= n_avg_in;
        issue_idx <= '0;
        busy      <= 1'b1;
        overrun   <= 1'b0;
      end else if (busy && !avg_ready) begin
        overrun <= 1'b1;
      end
      if (done_set) busy <= 1'b0;
    end
  end

  // Valid shift register aligned with bram_rdata.
  if (READ_LATENCY == 1) begin : g_sr1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_sr <= '0;
      else     vld_sr <= bram_en;
    end
  end else begin : g_srn
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_sr <= '0;
      else     vld_sr <= {vld_sr[READ_LATENCY-2:0], bram_en};
    end
  end

  // Output FIFO plus in-flight and returned-word tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_flight  <= '0;
      ret_idx    <= '0;
    end else begin
      if (accept) ret_idx <= '0;
      if (push) begin
        fifo_data[wr_ptr] <= bram_rdata;
        fifo_last[wr_ptr] <= ret_last;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        ret_idx           <= ret_idx + IDX_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      in_flight  <= in_flight + CNT_W'(issue) - CNT_W'(push);
    end
  end

endmodule

// File: doc/averager_reader.md
Name: averager_reader

Overview:
- Readout engine for the averager accumulation BRAM.
- Once the averager asserts ready, a start request makes it sweep BRAM words 0..count_max through the second BRAM port.
- Read data is streamed out on an AXI4-Stream master with full backpressure, and a tlast marks the final word.
- It latches n_avg so software gets the sum array together with its averaging count.

Parameters:
- FAST_COUNT_WIDTH, 13: word-index width; BRAM byte address is FAST_COUNT_WIDTH+2 bits.
- SLOW_COUNT_WIDTH, 19: width of n_avg.
- DATA_WIDTH, 32: BRAM read data and stream width.
- READ_LATENCY, 2: cycles from bram_en to valid bram_rdata; legal range 1..4.
- FIFO_DEPTH, 8: output buffer depth in words; must be a power of 2 and at least READ_LATENCY+2.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- start, in, 1: single-cycle request to read out one frame.
- avg_ready, in, 1: ready output of the averager counter.
- count_max, in, FAST_COUNT_WIDTH: last word index of the frame.
- n_avg_in, in, SLOW_COUNT_WIDTH: n_avg output of the averager counter.
- bram_addr, out, FAST_COUNT_WIDTH+2: byte address, equal to {word_index, 2'b00}.
- bram_en, out, 1: read enable.
- bram_rdata, in, DATA_WIDTH: read data.
- m_axis_tdata, out, DATA_WIDTH: stream data.
- m_axis_tvalid, out, 1: stream valid.
- m_axis_tready, in, 1: stream ready.
- m_axis_tlast, out, 1: asserted on word count_max.
- n_avg, out, SLOW_COUNT_WIDTH: n_avg latched at start.
- busy, out, 1: readout in progress.
- done, out, 1: one-cycle pulse after the last beat is accepted.
- overrun, out, 1: sticky; avg_ready fell during readout.

Behaviour:
- Reset values: bram_addr=0, bram_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, n_avg=0, busy=0, done=0, overrun=0, FIFO empty, state IDLE.
- State machine has three states: IDLE, READ and DRAIN.
- IDLE:
  - Transition to READ on start=1 && avg_ready=1.
  - On that edge: latch count_max into cmax_reg, latch n_avg_in into n_avg, set issue index=0, busy=1, overrun=0.
  - start while avg_ready=0 is ignored: no state change, no flag.
- start while busy=1 is ignored.
- READ, read issue:
  - A read is issued in a cycle when issue index <= cmax_reg and (in_flight + fifo_count) < FIFO_DEPTH.
  - Issuing means bram_en=1, bram_addr={index,2'b00}, index+1, all registered.
  - in_flight is the count of reads issued whose data has not yet returned.
  - This credit rule guarantees the FIFO never overflows; no read is ever dropped.
- Data capture:
  - A READ_LATENCY-deep valid shift register tracks issued reads.
  - When its output bit is 1, bram_rdata is written to the FIFO together with a last flag = (returned word index == cmax_reg).
- Transition to DRAIN after the read of index cmax_reg is issued; no further bram_en.
- DRAIN:
  - On a beat with tlast (tvalid && tready && tlast): done=1 for one cycle the following cycle, busy=0, return to IDLE.
- Stream rules:
  - tvalid=1 whenever the FIFO is non-empty; tdata and tlast come from the FIFO head.
  - Once asserted, tvalid and tdata stay stable until tready.
  - Simultaneous FIFO push and pop is allowed, with count unchanged.
  - Maximum throughput is 1 word per clock with tready held high.
  - First tvalid appears READ_LATENCY+2 cycles after the start edge.
- Frame size:
  - Frame length is cmax_reg+1 words.
  - cmax_reg=0 gives a single beat with tlast=1.
  - Full-scale cmax_reg = 2^FAST_COUNT_WIDTH-1: the index counter is FAST_COUNT_WIDTH+1 bits so the <= compare terminates without wrapping.
- Changes to count_max or n_avg_in during busy have no effect.
- overrun is set in any cycle with busy=1 && avg_ready=0. Readout continues to completion; overrun clears only on the next accepted start.
- rst asserted mid-frame: all outputs take their reset values immediately; the FIFO and in-flight tracking are flushed.
  - Data still returning from the BRAM after reset release is discarded: the valid shift register is cleared.

Test Plan:
- Nominal frame:
  - Stimulus: count_max=7, BRAM word i = 0x100+i, n_avg_in=5, tready=1, start with avg_ready=1.
  - Response: 8 back-to-back beats 0x100..0x107; tlast only on 0x107; n_avg=5; done pulses once; bram_addr steps 0x00,0x04..0x1C.
- Backpressure:
  - Stimulus: count_max=31, tready toggled randomly including a 20-cycle low stretch.
  - Response: all 32 words in order, no duplicates or drops; tdata stable while tvalid && !tready; bram_en stops once in_flight+fifo_count reaches FIFO_DEPTH.
- Start rules:
  - start with avg_ready=0 -> no bram_en, busy stays 0.
  - start during busy -> frame unaffected, still exactly count_max+1 beats.
- Overrun: drop avg_ready at beat 3 of a count_max=15 frame -> overrun=1 held through done; all 16 beats still delivered; next start clears overrun.
- Edge sizes:
  - count_max=0 -> one beat with tlast=1, then done.
  - count_max=8191 at FAST_COUNT_WIDTH=13 -> 8192 beats, last bram_addr=0x7FFC.
- Reset mid-frame: assert rst at beat 10 of 64 -> tvalid=0, busy=0 within the same cycle; a new start after release streams from word 0 with no stale data.
